rs232_tx_fifo: RTL and testbench

//   Byte FIFO and transmit sequencer feeding the rs232 serial transmitter.

---
 rtl/rs232_tx_fifo.sv | 91 +++++++++
 tb/tb_rs232_tx_fifo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO plus transmit sequencer for the rs232 transmitter: queues bytes and
// issues one TX_Request per byte, holding TX_Data until rs232 drops Busy.
module rs232_tx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              USER_CLK,
   input  logic              Reset,
   input  logic              Wr_En,
   input  logic [7:0]        Wr_Data,
   output logic              Full,
   output logic              Empty,
   output logic [ADDR_W:0]   Count,
   output logic              Overflow,
   output logic              TX_Request,
   output logic [7:0]        TX_Data,
   input  logic              Busy
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_HI, WAIT_LO} state_t;

   state_t            state, state_nxt;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              push, pop;
   logic [ADDR_W:0]   count_nxt;

   // Full is the registered flag, so a push while Full is dropped even during a pop
   always_comb begin
      push = Wr_En && !Full;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (!Empty && !Busy) begin
               pop       = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ:     state_nxt = WAIT_HI;
         WAIT_HI: if (Busy)  state_nxt = WAIT_LO;
         WAIT_LO: if (!Busy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      count_nxt = Count;
      if (push && !pop)
         count_nxt = Count + 1'b1;
      else if (!push && pop)
         count_nxt = Count - 1'b1;
   end

   always_ff @(posedge USER_CLK) begin
      if (push && !Reset)
         mem[wr_ptr] <= Wr_Data;
   end

   always_ff @(posedge USER_CLK) begin
      if (Reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         Count      <= '0;
         Empty      <= 1'b1;
         Full       <= 1'b0;
         Overflow   <= 1'b0;
         TX_Request <= 1'b0;
         TX_Data    <= '0;
      end else begin
         state      <= state_nxt;
         Count      <= count_nxt;
         Empty      <= (count_nxt == '0);
         Full       <= (count_nxt == (ADDR_W+1)'(DEPTH));
         TX_Request <= (state == REQ);
         if (Wr_En && Full)
            Overflow <= 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            TX_Data <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// Self-checking bench for rs232_tx_fifo: cycle vector table, directed frame
// scenarios against a simple rs232 responder, and randomized traffic vs a queue model.
module tb_rs232_tx_fifo;

   localparam int DEPTH = 16;

   logic       USER_CLK = 1'b0;
   logic       Reset    = 1'b1;
   logic       Wr_En    = 1'b0;
   logic [7:0] Wr_Data  = '0;
   logic       Busy     = 1'b0;
   logic       Full, Empty, Overflow, TX_Request;
   logic [4:0] Count;
   logic [7:0] TX_Data;

   rs232_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
      .USER_CLK(USER_CLK), .Reset(Reset), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
      .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
      .TX_Request(TX_Request), .TX_Data(TX_Data), .Busy(Busy)
   );

   always #5 USER_CLK = ~USER_CLK;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, wr;
      logic [7:0] din;
      logic       busy;
      int         cnt;
      logic       emp, ful, ovf, req;
      logic [7:0] txd;
   } vec_t;

   function automatic vec_t mk(logic rst, logic wr, logic [7:0] din, logic busy, int cnt,
                               logic emp, logic ful, logic ovf, logic req, logic [7:0] txd);
      vec_t v;
      v.rst = rst; v.wr = wr; v.din = din; v.busy = busy; v.cnt = cnt;
      v.emp = emp; v.ful = ful; v.ovf = ovf; v.req = req; v.txd = txd;
      return v;
   endfunction

   // ---------------- reference model (queue level) ----------------
   logic [7:0] m_q[$];
   logic [7:0] acc_q[$];
   logic       m_ovf = 0, m_req = 0, m_req_due = 0, m_inflight = 0;
   logic       m_await_hi = 0, m_await_lo = 0;
   logic [7:0] m_txd = '0;

   // ---------------- rs232 responder ----------------
   int         u_frame  = 0;
   int         u_bitlen = 3;
   logic       force_busy = 0;
   logic [7:0] u_shift;
   logic [7:0] rx_q[$];
   logic       line_q[$];
   int         n_req = 0;

   task automatic step();
      logic busy_pre, req_pre, rst_pre, wr_pre;
      logic [7:0] d_pre;
      logic do_pop, do_push;
      int elapsed, k;
      logic b;
      busy_pre = Busy; req_pre = TX_Request; rst_pre = Reset;
      wr_pre = Wr_En; d_pre = Wr_Data;
      if (rst_pre) begin
         m_q.delete(); acc_q.delete(); rx_q.delete(); line_q.delete();
         m_ovf = 0; m_req = 0; m_req_due = 0; m_inflight = 0;
         m_await_hi = 0; m_await_lo = 0; m_txd = '0;
      end else begin
         do_pop  = !m_inflight && (m_q.size() != 0) && !busy_pre;
         do_push = wr_pre && (m_q.size() < DEPTH);
         if (wr_pre && !do_push) m_ovf = 1;
         m_req = m_req_due;
         if (m_req_due) begin
            m_req_due = 0; m_await_hi = 1;
         end else if (m_await_hi) begin
            if (busy_pre) begin m_await_hi = 0; m_await_lo = 1; end
         end else if (m_await_lo) begin
            if (!busy_pre) begin m_await_lo = 0; m_inflight = 0; end
         end
         if (do_pop) begin
            m_txd = m_q.pop_front(); m_inflight = 1; m_req_due = 1;
         end
         if (do_push) begin
            m_q.push_back(d_pre); acc_q.push_back(d_pre);
         end
      end

      @(posedge USER_CLK); #1;

      if (rst_pre)          u_frame = 0;
      else if (u_frame > 0) u_frame--;
      else if (req_pre)     u_frame = 10 * u_bitlen;
      if (u_frame > 0) begin
         elapsed = 10 * u_bitlen - u_frame;
         if (elapsed % u_bitlen == 0) begin
            k = elapsed / u_bitlen;
            if (k == 0)      b = 1'b0;
            else if (k == 9) b = 1'b1;
            else begin
               b = TX_Data[k-1];
               u_shift[k-1] = b;
            end
            line_q.push_back(b);
            if (k == 9) rx_q.push_back(u_shift);
         end
      end
      Busy = (u_frame > 0) || force_busy;
      if (TX_Request) n_req++;

      chk("count",    int'(Count),      m_q.size());
      chk("empty",    int'(Empty),      int'(m_q.size() == 0));
      chk("full",     int'(Full),       int'(m_q.size() == DEPTH));
      chk("overflow", int'(Overflow),   int'(m_ovf));
      chk("tx_req",   int'(TX_Request), int'(m_req));
      chk("tx_data",  int'(TX_Data),    int'(m_txd));
   endtask

   task automatic do_reset();
      Reset = 1; Wr_En = 0;
      step();
      Reset = 0;
   endtask

   task automatic drain(input string nm, input int limit);
      logic done;
      done = 0;
      Wr_En = 0;
      for (int i = 0; i < limit; i++) begin
         if (m_q.size() == 0 && !m_inflight && !Busy && u_frame == 0) begin
            done = 1;
            break;
         end
         step();
      end
      chk({nm, "_drain_done"}, int'(done), 1);
   endtask

   task automatic cmp_rx(input string nm);
      chk({nm, "_rx_len"}, rx_q.size(), acc_q.size());
      for (int i = 0; i < rx_q.size() && i < acc_q.size(); i++)
         chk({nm, "_rx_byte"}, int'(rx_q[i]), int'(acc_q[i]));
   endtask

   initial begin
      vec_t tbl[$];
      logic exp_line[10];
      int   peak;

      // ---- cycle table: latency, foreign Busy hold, push+pop at Count=3, reset ----
      tbl.push_back(mk(1,0,8'h00,0, 0,1,0,0,0,8'h00));
      tbl.push_back(mk(0,1,8'hA5,0, 1,0,0,0,0,8'h00));
      tbl.push_back(mk(0,0,8'h00,0, 0,1,0,0,0,8'hA5));
      tbl.push_back(mk(0,0,8'h00,0, 0,1,0,0,1,8'hA5));
      tbl.push_back(mk(0,0,8'h00,0, 0,1,0,0,0,8'hA5));
      tbl.push_back(mk(0,0,8'h00,1, 0,1,0,0,0,8'hA5));
      tbl.push_back(mk(0,0,8'h00,1, 0,1,0,0,0,8'hA5));
      tbl.push_back(mk(0,0,8'h00,0, 0,1,0,0,0,8'hA5));
      tbl.push_back(mk(0,1,8'h11,1, 1,0,0,0,0,8'hA5));
      tbl.push_back(mk(0,1,8'h22,1, 2,0,0,0,0,8'hA5));
      tbl.push_back(mk(0,1,8'h33,1, 3,0,0,0,0,8'hA5));
      tbl.push_back(mk(0,0,8'h00,1, 3,0,0,0,0,8'hA5));
      tbl.push_back(mk(0,1,8'h44,0, 3,0,0,0,0,8'h11));
      tbl.push_back(mk(0,0,8'h00,0, 3,0,0,0,1,8'h11));
      tbl.push_back(mk(0,0,8'h00,0, 3,0,0,0,0,8'h11));
      tbl.push_back(mk(0,0,8'h00,1, 3,0,0,0,0,8'h11));
      tbl.push_back(mk(0,0,8'h00,0, 3,0,0,0,0,8'h11));
      tbl.push_back(mk(0,0,8'h00,0, 2,0,0,0,0,8'h22));
      tbl.push_back(mk(1,0,8'h00,0, 0,1,0,0,0,8'h00));
      tbl.push_back(mk(0,0,8'h00,0, 0,1,0,0,0,8'h00));

      for (int i = 0; i < tbl.size(); i++) begin
         Reset = tbl[i].rst; Wr_En = tbl[i].wr; Wr_Data = tbl[i].din; Busy = tbl[i].busy;
         @(posedge USER_CLK); #1;
         chk($sformatf("tbl%0d_count", i), int'(Count),      tbl[i].cnt);
         chk($sformatf("tbl%0d_empty", i), int'(Empty),      int'(tbl[i].emp));
         chk($sformatf("tbl%0d_full", i),  int'(Full),       int'(tbl[i].ful));
         chk($sformatf("tbl%0d_ovf", i),   int'(Overflow),   int'(tbl[i].ovf));
         chk($sformatf("tbl%0d_req", i),   int'(TX_Request), int'(tbl[i].req));
         chk($sformatf("tbl%0d_txd", i),   int'(TX_Data),    int'(tbl[i].txd));
      end
      Busy = 0; Wr_En = 0;

      // ---- single byte A5: one request, serial pattern on the line ----
      u_bitlen = 3;
      do_reset();
      n_req = 0;
      Wr_En = 1; Wr_Data = 8'hA5; step();
      Wr_En = 0;
      drain("t1", 200);
      repeat (20) step();
      chk("t1_req_pulses", n_req, 1);
      exp_line = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1};
      chk("t1_line_len", line_q.size(), 10);
      for (int i = 0; i < 10 && i < line_q.size(); i++)
         chk($sformatf("t1_line_bit%0d", i), int'(line_q[i]), int'(exp_line[i]));
      cmp_rx("t1");

      // ---- burst 01..05 ----
      do_reset();
      peak = 0;
      for (int i = 1; i <= 5; i++) begin
         Wr_En = 1; Wr_Data = 8'(i); step();
         if (int'(Count) > peak) peak = int'(Count);
      end
      Wr_En = 0;
      drain("t2", 800);
      chk("t2_count_peak", peak, 4);
      chk("t2_empty_end", int'(Empty), 1);
      cmp_rx("t2");

      // ---- overflow: 20 writes while first frame is in flight ----
      do_reset();
      for (int i = 0; i < 20; i++) begin
         Wr_En = 1; Wr_Data = 8'(8'h40 + i); step();
      end
      Wr_En = 0;
      chk("t3_full", int'(Full), 1);
      chk("t3_overflow", int'(Overflow), 1);
      chk("t3_accepted", acc_q.size(), 17);
      drain("t3", 2000);
      cmp_rx("t3");
      chk("t3_overflow_sticky", int'(Overflow), 1);

      // ---- reset mid-frame with bytes queued ----
      for (int i = 0; i < 6; i++) begin
         Wr_En = 1; Wr_Data = 8'(8'hC0 + i); step();
      end
      Wr_En = 0;
      for (int i = 0; i < 50 && !Busy; i++) step();
      chk("t5_busy_before_reset", int'(Busy), 1);
      do_reset();
      chk("t5_req",   int'(TX_Request), 0);
      chk("t5_txd",   int'(TX_Data), 0);
      chk("t5_count", int'(Count), 0);
      chk("t5_ovf",   int'(Overflow), 0);
      chk("t5_empty", int'(Empty), 1);
      n_req = 0;
      repeat (60) step();
      chk("t5_no_requests", n_req, 0);

      // ---- randomized traffic ----
      u_bitlen = 2;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         Reset   = ($urandom_range(0, 499) == 0);
         Wr_En   = ($urandom_range(0, 2) == 0);
         Wr_Data = 8'($urandom);
         if ($urandom_range(0, 79) == 0) force_busy = !force_busy;
         step();
      end
      Reset = 0; force_busy = 0;
      drain("rand", 3000);
      cmp_rx("rand");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
